// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// UART_TX_ARB_PARITY_EN adds the PARITY state to the frame sequencer.
package uart_pkg;

  localparam int DATA_BITS   = 8;
  localparam int OVS_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_ARB_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of the shared UART transmitter: requests, bytes,
// grants, line status and the oversampling strobe.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NREQ = 4
);
  logic                      tick_in;
  logic [NREQ-1:0]           req;
  logic [NREQ*DATA_BITS-1:0] data;
  logic [NREQ-1:0]           gnt;
  logic                      busy;
  logic                      done;
  logic                      dcom;

  modport master (output tick_in, req, data, input gnt, busy, done, dcom);
  modport slave  (input tick_in, req, data, output gnt, busy, done, dcom);
endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo NREQ.
module uart_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  int slot;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    slot    = 0;
    for (int i = 0; i < NREQ; i++) begin
      slot = int'(ptr) + i;
      if (slot >= NREQ) slot = slot - NREQ;
      if (!any && req[slot]) begin
        any       = 1'b1;
        win[slot] = 1'b1;
        win_idx   = IDX_W'(slot);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin shared UART transmitter: grants one requester, latches its byte
// and sends it 8N1 on dcom. Define UART_TX_ARB_PARITY_EN for an even-parity bit.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int OVS  = OVS_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVS - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   dcom_q, dcom_d;
  logic                   done_q, done_d;
  logic [NREQ-1:0]        gnt_c;
  logic [NREQ-1:0]        win;
  logic [IDX_W-1:0]       win_idx;
  logic                   any;
  logic                   bit_end;
`ifdef UART_TX_ARB_PARITY_EN
  logic                   par_q, par_d;
`endif

  uart_rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  assign bit_end = bus.tick_in && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    gnt_c   = '0;
    dcom_d  = 1'b1;
`ifdef UART_TX_ARB_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != ST_IDLE && bus.tick_in)
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      // The done cycle is already IDLE but must not grant; arbitration resumes next cycle.
      ST_IDLE: if (any && !done_q) begin
        gnt_c   = win;
        shift_d = bus.data[{win_idx, 3'b000} +: DATA_BITS];
        ptr_d   = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
        state_d = ST_START;
`ifdef UART_TX_ARB_PARITY_EN
        par_d   = even_parity(bus.data[{win_idx, 3'b000} +: DATA_BITS]);
`endif
      end
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        if (bit_q == BIT_LAST) begin
          bit_d = '0;
`ifdef UART_TX_ARB_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
`ifdef UART_TX_ARB_PARITY_EN
      ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
      ST_STOP: if (bit_end) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is registered from the next state so it lines up with the state change.
    case (state_d)
      ST_START:  dcom_d = 1'b0;
      ST_DATA:   dcom_d = shift_d[0];
`ifdef UART_TX_ARB_PARITY_EN
      ST_PARITY: dcom_d = par_q;
`endif
      default:   dcom_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      ptr_q   <= '0;
      dcom_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ptr_q   <= ptr_d;
      dcom_q  <= dcom_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_TX_ARB_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign bus.gnt  = rst_n ? gnt_c : '0;
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.dcom = dcom_q;

endmodule
